// File: rtl/lenet_pkg.sv
// Shared LeNet definitions.
// Contents: the FC2 argmax FSM encoding, the SRAM f word/lane geometry and the
// default number of FC2 classes.
package lenet_pkg;

  localparam int unsigned NUM_CLASS_DEF  = 10;
  localparam int unsigned SRAM_WORD_W    = 32;
  localparam int unsigned LANES_PER_WORD = 4;
  localparam int unsigned LANE_W         = SRAM_WORD_W / LANES_PER_WORD;
  localparam logic [1:0]  LAST_LANE      = 2'(LANES_PER_WORD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOAD,
    ST_SCAN,
    ST_DONE
  } argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Signed compare-and-select for the running argmax.
// Ports:
//   score/index       candidate score and its class index
//   cur_max/cur_idx   running maximum and its class index
//   first             load the candidate unconditionally (first class)
//   next_max/next_idx updated running maximum and index
// Strict greater-than keeps the lower index on ties.
module argmax_cmp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IDX_W      = 4
) (
  input  logic [DATA_WIDTH-1:0] score,
  input  logic [IDX_W-1:0]      index,
  input  logic [DATA_WIDTH-1:0] cur_max,
  input  logic [IDX_W-1:0]      cur_idx,
  input  logic                  first,
  output logic [DATA_WIDTH-1:0] next_max,
  output logic [IDX_W-1:0]      next_idx
);

  logic take;

  always_comb begin
    take     = first || ($signed(score) > $signed(cur_max));
    next_max = take ? score : cur_max;
    next_idx = take ? index : cur_idx;
  end

endmodule

// File: rtl/fc_argmax.sv
// FC2 argmax: after fc2_done, reads the FC2 scores from SRAM f (four signed
// bytes per word, lane 0 in bits [31:24]) and reports the index and value of
// the largest score.
// Ports:
//   clk, srstn        clock, synchronous active-low reset
//   fc2_done          start pulse (ignored while busy)
//   sram_raddr_f      registered SRAM f word address
//   sram_rdata_f      SRAM f read word, valid one cycle after the address
//   busy              high in every state except IDLE
//   result_valid      one-cycle completion pulse
//   result_class      index of the maximum score (held between completions)
//   result_score      maximum score (held between completions)
module fc_argmax
  import lenet_pkg::*;
#(
  parameter int unsigned NUM_CLASS  = NUM_CLASS_DEF,
  parameter int unsigned DATA_WIDTH = LANE_W
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  fc2_done,
  output logic [1:0]            sram_raddr_f,
  input  logic [31:0]           sram_rdata_f,
  output logic                  busy,
  output logic                  result_valid,
  output logic [3:0]            result_class,
  output logic [DATA_WIDTH-1:0] result_score
);

  localparam logic [3:0] IDX_LAST = 4'(NUM_CLASS - 1);

  argmax_state_t         state, state_nxt;
  logic [31:0]           word;
  logic [1:0]            lane;
  logic [3:0]            cls_idx;
  logic [DATA_WIDTH-1:0] max_score, score, next_max;
  logic [3:0]            max_idx, next_idx;
  logic                  scan_last;

  assign scan_last = (cls_idx == IDX_LAST);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    case (lane)
      2'd1:    score = word[SRAM_WORD_W-1-LANE_W   -: DATA_WIDTH];
      2'd2:    score = word[SRAM_WORD_W-1-2*LANE_W -: DATA_WIDTH];
      2'd3:    score = word[SRAM_WORD_W-1-3*LANE_W -: DATA_WIDTH];
      default: score = word[SRAM_WORD_W-1          -: DATA_WIDTH];
    endcase
  end

  argmax_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (4)
  ) u_cmp (
    .score    (score),
    .index    (cls_idx),
    .cur_max  (max_score),
    .cur_idx  (max_idx),
    .first    (cls_idx == '0),
    .next_max (next_max),
    .next_idx (next_idx)
  );

  always_ff @(posedge clk) begin
    if (!srstn) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (fc2_done) state_nxt = ST_REQ;
      ST_REQ:  state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (scan_last)              state_nxt = ST_DONE;
        else if (lane == LAST_LANE) state_nxt = ST_REQ;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The result registers are loaded on the edge entering DONE (straight from
  // the comparator) so result_valid and the new result are visible together
  // during the DONE cycle.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      sram_raddr_f <= '0;
      word         <= '0;
      lane         <= '0;
      cls_idx      <= '0;
      max_score    <= '0;
      max_idx      <= '0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_score <= '0;
    end else begin
      result_valid <= (state == ST_SCAN) && scan_last;
      case (state)
        ST_IDLE: begin
          if (fc2_done) begin
            sram_raddr_f <= '0;
            cls_idx      <= '0;
          end
        end
        ST_LOAD: begin
          word <= sram_rdata_f;
          lane <= '0;
        end
        ST_SCAN: begin
          max_score <= next_max;
          max_idx   <= next_idx;
          lane      <= lane + 2'd1;
          cls_idx   <= cls_idx + 4'd1;
          if (scan_last) begin
            result_class <= next_idx;
            result_score <= next_max;
          end else if (lane == LAST_LANE) begin
            sram_raddr_f <= sram_raddr_f + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax.sv
// Self-checking bench for fc_argmax: SRAM f model, directed corner cases and
// randomized score sets checked against a plain argmax reference.
module tb_fc_argmax;

  localparam int NCLS = 10;

  logic        clk = 1'b0;
  logic        srstn;
  logic        fc2_done;
  logic [1:0]  sram_raddr_f;
  logic [31:0] sram_rdata_f;
  logic        busy;
  logic        result_valid;
  logic [3:0]  result_class;
  logic [7:0]  result_score;

  logic [31:0] mem [4];
  logic [7:0]  scores [16];

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) sram_rdata_f <= mem[sram_raddr_f];

  fc_argmax #(
    .NUM_CLASS  (NCLS),
    .DATA_WIDTH (8)
  ) dut (
    .clk          (clk),
    .srstn        (srstn),
    .fc2_done     (fc2_done),
    .sram_raddr_f (sram_raddr_f),
    .sram_rdata_f (sram_rdata_f),
    .busy         (busy),
    .result_valid (result_valid),
    .result_class (result_class),
    .result_score (result_score)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Class k lives in word k/4, lane k%4, lane 0 in the top byte.
  task automatic load_mem();
    for (int w = 0; w < 4; w++)
      mem[w] = {scores[4*w], scores[4*w+1], scores[4*w+2], scores[4*w+3]};
  endtask

  task automatic ref_model(output int cls, output int sc);
    int v;
    cls = 0;
    sc  = $signed(scores[0]);
    for (int i = 1; i < NCLS; i++) begin
      v = $signed(scores[i]);
      if (v > sc) begin
        sc  = v;
        cls = i;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":busy"},  32'(busy), 32'd0);
    check({tag, ":valid"}, 32'(result_valid), 32'd0);
    check({tag, ":class"}, 32'(result_class), 32'd0);
    check({tag, ":score"}, 32'(result_score), 32'd0);
    check({tag, ":raddr"}, 32'(sram_raddr_f), 32'd0);
  endtask

  // Called at a negedge; pulses fc2_done for the current cycle.
  task automatic run_scan(input string tag);
    int exp_cls, exp_sc, n;
    logic [1:0] seq [$];
    load_mem();
    ref_model(exp_cls, exp_sc);
    fc2_done = 1'b1;
    @(negedge clk);
    fc2_done = 1'b0;
    n = 1;
    while (!result_valid && n < 40) begin
      if (busy && (seq.size() == 0 || seq[$] != sram_raddr_f)) seq.push_back(sram_raddr_f);
      @(negedge clk);
      n++;
    end
    check({tag, ":latency"}, 32'(n), 32'd17);
    check({tag, ":class"}, 32'(result_class), 32'(exp_cls));
    check({tag, ":score"}, 32'(result_score), 32'(exp_sc & 255));
    check({tag, ":addr_count"}, 32'(seq.size()), 32'd3);
    for (int i = 0; i < seq.size() && i < 3; i++)
      check({tag, ":addr_seq"}, 32'(seq[i]), 32'(i));
    @(negedge clk);
    check({tag, ":pulse"}, 32'(result_valid), 32'd0);
    repeat (2) @(negedge clk);
    check({tag, ":hold_class"}, 32'(result_class), 32'(exp_cls));
    check({tag, ":hold_score"}, 32'(result_score), 32'(exp_sc & 255));
    check({tag, ":idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int exp_cls, exp_sc, pulses, vcyc;
    logic [7:0] t033 [10];
    t033 = '{8'd5, 8'hFD, 8'd12, 8'd7, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'h80};

    srstn    = 1'b0;
    fc2_done = 1'b0;
    for (int w = 0; w < 4; w++) mem[w] = '0;
    for (int i = 0; i < 16; i++) scores[i] = 8'h7F;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    srstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NCLS; i++) scores[i] = t033[i];
    run_scan("mixed");

    // Reset in cycle +9 of a scan aborts it without a result.
    load_mem();
    fc2_done = 1'b1;
    @(negedge clk);
    fc2_done = 1'b0;
    repeat (8) @(negedge clk);
    srstn = 1'b0;
    @(negedge clk);
    srstn = 1'b1;
    check_reset_outputs("abort");
    pulses = 0;
    repeat (20) begin
      if (result_valid) pulses++;
      @(negedge clk);
    end
    check("abort:no_valid", 32'(pulses), 32'd0);
    run_scan("after_abort");

    for (int i = 0; i < NCLS; i++) scores[i] = 8'h80;
    run_scan("all_min");

    for (int i = 0; i < NCLS; i++) scores[i] = 8'h00;
    scores[3] = 8'h7F;
    scores[9] = 8'h7F;
    run_scan("tie_max");

    // Pulses at +5 (busy) and +17 (DONE) are ignored; +18 starts a new scan.
    for (int i = 0; i < NCLS; i++) scores[i] = 8'($urandom_range(0, 255));
    load_mem();
    ref_model(exp_cls, exp_sc);
    fc2_done = 1'b1;
    @(negedge clk);
    pulses = 0;
    vcyc   = 0;
    for (int n = 1; n <= 17; n++) begin
      if (result_valid) begin
        pulses++;
        vcyc = n;
      end
      fc2_done = (n == 5 || n == 17);
      @(negedge clk);
    end
    fc2_done = 1'b0;
    check("busy_pulse:count", 32'(pulses), 32'd1);
    check("busy_pulse:cycle", 32'(vcyc), 32'd17);
    check("busy_pulse:class", 32'(result_class), 32'(exp_cls));
    check("busy_pulse:no_restart", 32'(busy), 32'd0);
    check("busy_pulse:valid_low", 32'(result_valid), 32'd0);
    for (int i = 0; i < NCLS; i++) scores[i] = 8'($urandom_range(0, 255));
    run_scan("restart_18");

    for (int i = 0; i < NCLS; i++) scores[i] = 8'($urandom_range(128, 255));
    scores[9]  = 8'h01;
    scores[10] = 8'h7F;
    scores[11] = 8'h7F;
    run_scan("max_last");

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 16; i++) begin
        if (r % 2 == 0) scores[i] = 8'($urandom_range(0, 255));
        else            scores[i] = 8'($urandom_range(0, 3) * 64);
      end
      run_scan("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
